pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised program-counter generator; successor to the single-width PC register.
- Sits between control/ALU and instruction fetch.
- Computes the next PC from a 3-bit `pc_src` mode plus ALU flags (`alu_zero`, `alu_lt`). Adds the signed-branch modes and the `mret` mode.
- Presents the PC to fetch with a valid/ready handshake. Adds stall, misaligned-target traps, external trap entry, an EPC register and a retired-instruction counter.

Parameters:
ADDR_W, 32, PC/address width in bits (≥16)
RESET_VEC, 32'h1000, PC loaded on reset (ADDR_W bits)
TRAP_VEC, 32'h2000, PC loaded on trap entry (ADDR_W bits)
IALIGN, 4, instruction alignment in bytes; legal values 2 or 4
CNT_W, 32, retired-counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
pc_src  in  3  next-PC mode (encoding below)
tar_addr  in  ADDR_W  branch/JAL target
alu_res  in  ADDR_W  JALR target
alu_zero  in  1  ALU result == 0
alu_lt  in  1  ALU signed less-than
stall  in  1  hold PC (hazard)
trap_req  in  1  external trap request
pc_ready  in  1  fetch accepts current PC
pc_out  out  ADDR_W  current PC
pc_valid  out  1  pc_out is valid for fetch
epc  out  ADDR_W  PC saved on trap
trap_taken  out  1  one-cycle pulse on trap entry
trap_cause  out  2  0=none, 1=misaligned target, 2=external
retired  out  CNT_W  count of accepted PCs

Behaviour:
- Clock is `clk`. Reset is `rst`: synchronous, active-high, sampled on the rising edge.
- Reset values:
  - pc_out=RESET_VEC, pc_valid=0, epc=0, trap_taken=0, trap_cause=0, retired=0.
  - State = BOOT.
- States:
  - BOOT: pc_valid=0; always goes to RUN on the next cycle.
  - RUN: pc_valid=1.
  - TRAP: pc_valid=0; lasts one cycle, then RUN.
- advance = (state==RUN) && pc_valid && pc_ready && !stall && !trap_req.
- pc_src encoding. "taken" selects the target; otherwise next = pc_out+4.
  - 000: pc_out+4.
  - 001: tar_addr if alu_zero.
  - 010: tar_addr if !alu_zero.
  - 011: tar_addr, unconditional.
  - 100: {alu_res[ADDR_W-1:1],1'b0} (JALR clears bit 0).
  - 101: tar_addr if alu_lt.
  - 110: tar_addr if !alu_lt.
  - 111: epc (mret).
- Sequential increment is always +4. All address arithmetic is modulo 2^ADDR_W: PC 0xFFFF_FFFC+4 wraps to 0 silently, with no trap.
- Misalignment applies only to a taken target, including epc under mode 111.
  - IALIGN=4: misaligned when target[1:0]!=0.
  - IALIGN=2: misaligned when target[0]!=0.
- Priority, highest first: rst > trap_req > stall > advance.
- trap_req in RUN or BOOT:
  - epc<=pc_out, pc_out<=TRAP_VEC, trap_cause<=2, trap_taken=1 for one cycle.
  - State<=TRAP.
  - pc_ready is ignored.
- trap_req while already in TRAP: ignored, with no re-entry and no epc overwrite.
- advance with a misaligned taken target:
  - epc<=pc_out (the faulting instruction), pc_out<=TRAP_VEC, trap_cause<=1, trap_taken pulse.
  - State<=TRAP.
  - retired does NOT increment.
- advance with a legal target: pc_out<=next, retired<=retired+1 (wraps at 2^CNT_W).
- stall=1, or pc_ready=0, in RUN: pc_out, retired and epc all hold. Inputs may change freely meanwhile; only the values on the advance cycle matter.
- trap_cause holds its last value until the next trap or reset.
- trap_taken is asserted only in the cycle following the trap-entry edge, i.e. registered, high for exactly one cycle.
- Reset during TRAP or mid-stall: all outputs return to their reset values on that edge; BOOT follows.
- Entering TRAP does not change retired.
- Latency:
  - New pc_out is visible the cycle after the advance edge.
  - Trap vector is visible the cycle after the trap edge, with pc_valid=0 for that one cycle, then 1.

Test Plan:
1. Reset, then pc_ready=1, pc_src=000 for 4 cycles -> cycle after rst: pc_valid=0, pc_out=0x1000; then pc_out 0x1000,0x1004,0x1008,0x100C; retired=3 after 3 advances.
2. pc_out=0x1010, pc_src=001, tar_addr=0x1100, alu_zero=0 -> 0x1014; repeat with alu_zero=1 -> 0x1100. Then pc_src=101, alu_lt=1, tar=0x1200 -> 0x1200; pc_src=110, alu_lt=1 -> 0x1204.
3. pc_src=100, alu_res=0x3007 -> pc_out=0x3006 with IALIGN=2; with IALIGN=4 -> trap: pc_out=0x2000, epc=0x3000 (the faulting PC), trap_cause=1, trap_taken one cycle, pc_valid=0 one cycle, retired unchanged.
4. stall=1 for 3 cycles with pc_ready=1, pc_src=011, tar=0x4000 -> pc_out and retired hold; on stall release pc_out=0x4000 next cycle. Same result holding pc_ready=0 instead of stall.
5. trap_req=1 while stall=1 at pc_out=0x1234 -> epc=0x1234, pc_out=0x2000, trap_cause=2; trap_req held 2 cycles -> single trap_taken pulse. Later pc_src=111 -> pc_out=0x1234.
6. Wrap and reset: pc_out=0xFFFFFFFC, pc_src=000 -> 0x00000000 with no trap. Assert rst during a TRAP cycle -> pc_out=0x1000, epc=0, retired=0, pc_valid=0.

Source files
------------

// File: rtl/pc_gen.sv
// Program-counter generator: next-PC select, fetch handshake,
// alignment/external trap entry, EPC and retired counter.
module pc_gen #(
  parameter int unsigned          ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]    RESET_VEC = 'h1000,
  parameter logic [ADDR_W-1:0]    TRAP_VEC  = 'h2000,
  parameter int unsigned          IALIGN    = 4,
  parameter int unsigned          CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        pc_src,
  input  logic [ADDR_W-1:0] tar_addr,
  input  logic [ADDR_W-1:0] alu_res,
  input  logic              alu_zero,
  input  logic              alu_lt,
  input  logic              stall,
  input  logic              trap_req,
  input  logic              pc_ready,
  output logic [ADDR_W-1:0] pc_out,
  output logic              pc_valid,
  output logic [ADDR_W-1:0] epc,
  output logic              trap_taken,
  output logic [1:0]        trap_cause,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_TRAP
  } state_e;

  localparam logic [2:0] SRC_SEQ  = 3'b000;
  localparam logic [2:0] SRC_BEQ  = 3'b001;
  localparam logic [2:0] SRC_BNE  = 3'b010;
  localparam logic [2:0] SRC_JAL  = 3'b011;
  localparam logic [2:0] SRC_JALR = 3'b100;
  localparam logic [2:0] SRC_BLT  = 3'b101;
  localparam logic [2:0] SRC_BGE  = 3'b110;
  localparam logic [2:0] SRC_MRET = 3'b111;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_MISA = 2'd1;
  localparam logic [1:0] CAUSE_EXT  = 2'd2;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   epc_q, epc_d;
  logic [1:0]          cause_q, cause_d;
  logic                tk_q, tk_d;
  logic [CNT_W-1:0]    ret_q, ret_d;

  logic [ADDR_W-1:0]   seq_pc;
  logic [ADDR_W-1:0]   target;
  logic [ADDR_W-1:0]   next_pc;
  logic                taken;
  logic                misa;
  logic                valid;
  logic                advance;

  assign valid   = (state_q == S_RUN);
  assign advance = valid & pc_ready & ~stall & ~trap_req;
  assign seq_pc  = pc_q + ADDR_W'(4);

  always_comb begin
    target = tar_addr;
    taken  = 1'b0;
    unique case (pc_src)
      SRC_SEQ:  taken = 1'b0;
      SRC_BEQ:  taken = alu_zero;
      SRC_BNE:  taken = ~alu_zero;
      SRC_JAL:  taken = 1'b1;
      SRC_JALR: begin
        taken  = 1'b1;
        target = alu_res & ~ADDR_W'(1);
      end
      SRC_BLT:  taken = alu_lt;
      SRC_BGE:  taken = ~alu_lt;
      SRC_MRET: begin
        taken  = 1'b1;
        target = epc_q;
      end
      default:  taken = 1'b0;
    endcase
  end

  // Only a taken target can fault; the +4 path wraps silently.
  always_comb begin
    if (IALIGN == 2) misa = taken & target[0];
    else             misa = taken & (|target[1:0]);
    next_pc = taken ? target : seq_pc;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    tk_d    = 1'b0;
    ret_d   = ret_q;
    unique case (state_q)
      S_BOOT: begin
        if (trap_req) begin
          state_d = S_TRAP;
          epc_d   = pc_q;
          pc_d    = TRAP_VEC;
          cause_d = CAUSE_EXT;
          tk_d    = 1'b1;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (trap_req) begin
          state_d = S_TRAP;
          epc_d   = pc_q;
          pc_d    = TRAP_VEC;
          cause_d = CAUSE_EXT;
          tk_d    = 1'b1;
        end else if (advance && misa) begin
          state_d = S_TRAP;
          epc_d   = pc_q;
          pc_d    = TRAP_VEC;
          cause_d = CAUSE_MISA;
          tk_d    = 1'b1;
        end else if (advance) begin
          pc_d  = next_pc;
          ret_d = ret_q + CNT_W'(1);
        end
      end
      S_TRAP: state_d = S_RUN;
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_VEC;
      epc_q   <= '0;
      cause_q <= CAUSE_NONE;
      tk_q    <= 1'b0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      tk_q    <= tk_d;
      ret_q   <= ret_d;
    end
  end

  assign pc_out     = pc_q;
  assign pc_valid   = valid;
  assign epc        = epc_q;
  assign trap_taken = tk_q;
  assign trap_cause = cause_q;
  assign retired    = ret_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: directed cycles push expected
// outputs; a monitor pops and compares one entry per clock.
module tb_pc_gen;

  typedef struct packed {
    logic        sel;
    logic [31:0] pc;
    logic        v;
    logic [31:0] epc;
    logic [1:0]  cause;
    logic        tk;
    logic [31:0] ret;
  } exp_t;

  logic        clk = 1'b0;
  logic        ra, rb;
  logic [2:0]  src;
  logic [31:0] tar, alu;
  logic        z, lt, st, tr, rdy;
  logic        sel;

  logic [31:0] a_pc, a_epc, a_ret;
  logic        a_v, a_tk;
  logic [1:0]  a_cause;
  logic [31:0] b_pc, b_epc, b_ret;
  logic        b_v, b_tk;
  logic [1:0]  b_cause;

  exp_t  q[$];
  string nq[$];
  int    n_vec = 0;
  int    n_bad = 0;

  always #5 clk = ~clk;

  pc_gen u_a (
    .clk(clk), .rst(ra), .pc_src(src),
    .tar_addr(tar), .alu_res(alu),
    .alu_zero(z), .alu_lt(lt), .stall(st),
    .trap_req(tr), .pc_ready(rdy),
    .pc_out(a_pc), .pc_valid(a_v), .epc(a_epc),
    .trap_taken(a_tk), .trap_cause(a_cause),
    .retired(a_ret)
  );

  pc_gen #(.IALIGN(2)) u_b (
    .clk(clk), .rst(rb), .pc_src(src),
    .tar_addr(tar), .alu_res(alu),
    .alu_zero(z), .alu_lt(lt), .stall(st),
    .trap_req(tr), .pc_ready(rdy),
    .pc_out(b_pc), .pc_valid(b_v), .epc(b_epc),
    .trap_taken(b_tk), .trap_cause(b_cause),
    .retired(b_ret)
  );

  task automatic cyc(input string nm,
                     input logic [31:0] pc,
                     input logic v,
                     input logic [31:0] e_epc,
                     input logic [1:0] cause,
                     input logic tk,
                     input logic [31:0] ret);
    exp_t e;
    e.sel   = sel;
    e.pc    = pc;
    e.v     = v;
    e.epc   = e_epc;
    e.cause = cause;
    e.tk    = tk;
    e.ret   = ret;
    q.push_back(e);
    nq.push_back(nm);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t  e;
    exp_t  a;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e  = q.pop_front();
        nm = nq.pop_front();
        a.sel = e.sel;
        if (e.sel) begin
          a.pc = b_pc; a.v = b_v; a.epc = b_epc;
          a.cause = b_cause; a.tk = b_tk; a.ret = b_ret;
        end else begin
          a.pc = a_pc; a.v = a_v; a.epc = a_epc;
          a.cause = a_cause; a.tk = a_tk; a.ret = a_ret;
        end
        n_vec++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL %s: got pc=%h v=%b epc=%h cause=%0d tk=%b ret=%0d, want pc=%h v=%b epc=%h cause=%0d tk=%b ret=%0d",
                   nm, a.pc, a.v, a.epc, a.cause, a.tk, a.ret,
                   e.pc, e.v, e.epc, e.cause, e.tk, e.ret);
        end
      end
    end
  end

  initial begin : stim
    ra = 1; rb = 1; sel = 1;
    src = 3'b000; tar = 0; alu = 0;
    z = 0; lt = 0; st = 0; tr = 0; rdy = 1;
    @(negedge clk);

    // IALIGN=2 instance: JALR to an odd address is legal
    cyc("b_rst", 32'h1000, 0, 0, 0, 0, 0);
    rb = 0;
    cyc("b_boot", 32'h1000, 1, 0, 0, 0, 0);
    src = 3'b011; tar = 32'h3000;
    cyc("b_jal", 32'h3000, 1, 0, 0, 0, 1);
    src = 3'b100; alu = 32'h3007;
    cyc("b_jalr", 32'h3006, 1, 0, 0, 0, 2);
    rb = 1; sel = 0;

    cyc("rst", 32'h1000, 0, 0, 0, 0, 0);
    ra = 0; src = 3'b000; tar = 0; alu = 0;
    cyc("boot", 32'h1000, 1, 0, 0, 0, 0);
    cyc("seq1", 32'h1004, 1, 0, 0, 0, 1);
    cyc("seq2", 32'h1008, 1, 0, 0, 0, 2);
    cyc("seq3", 32'h100C, 1, 0, 0, 0, 3);
    cyc("seq4", 32'h1010, 1, 0, 0, 0, 4);

    src = 3'b001; tar = 32'h1100; z = 0;
    cyc("beq_nt", 32'h1014, 1, 0, 0, 0, 5);
    z = 1;
    cyc("beq_t", 32'h1100, 1, 0, 0, 0, 6);
    src = 3'b101; tar = 32'h1200; lt = 1;
    cyc("blt_t", 32'h1200, 1, 0, 0, 0, 7);
    src = 3'b110; tar = 32'h1300;
    cyc("bge_nt", 32'h1204, 1, 0, 0, 0, 8);
    src = 3'b010; tar = 32'h1240; z = 1;
    cyc("bne_nt", 32'h1208, 1, 0, 0, 0, 9);
    z = 0;
    cyc("bne_t", 32'h1240, 1, 0, 0, 0, 10);
    src = 3'b110; tar = 32'h1280; lt = 0;
    cyc("bge_t", 32'h1280, 1, 0, 0, 0, 11);
    src = 3'b101; tar = 32'h1300;
    cyc("blt_nt", 32'h1284, 1, 0, 0, 0, 12);

    src = 3'b011; tar = 32'h3000;
    cyc("jal", 32'h3000, 1, 0, 0, 0, 13);
    src = 3'b100; alu = 32'h3007;
    cyc("jalr_misa", 32'h2000, 0, 32'h3000, 1, 1, 13);
    src = 3'b000;
    cyc("trap_hold", 32'h2000, 1, 32'h3000, 1, 0, 13);
    cyc("post_trap", 32'h2004, 1, 32'h3000, 1, 0, 14);
    src = 3'b001; tar = 32'h1002; z = 0;
    cyc("misa_nt", 32'h2008, 1, 32'h3000, 1, 0, 15);
    z = 1;
    cyc("beq_misa", 32'h2000, 0, 32'h2008, 1, 1, 15);
    src = 3'b000; z = 0;
    cyc("trap2_hold", 32'h2000, 1, 32'h2008, 1, 0, 15);
    cyc("post_trap2", 32'h2004, 1, 32'h2008, 1, 0, 16);

    src = 3'b011; tar = 32'h4000; st = 1;
    cyc("stall1", 32'h2004, 1, 32'h2008, 1, 0, 16);
    cyc("stall2", 32'h2004, 1, 32'h2008, 1, 0, 16);
    cyc("stall3", 32'h2004, 1, 32'h2008, 1, 0, 16);
    st = 0;
    cyc("unstall", 32'h4000, 1, 32'h2008, 1, 0, 17);
    rdy = 0; tar = 32'h5000;
    cyc("nrdy1", 32'h4000, 1, 32'h2008, 1, 0, 17);
    tar = 32'h6000;
    cyc("nrdy2", 32'h4000, 1, 32'h2008, 1, 0, 17);
    rdy = 1; tar = 32'h5000;
    cyc("rdy", 32'h5000, 1, 32'h2008, 1, 0, 18);
    tar = 32'h1234;
    cyc("to1234", 32'h1234, 1, 32'h2008, 1, 0, 19);

    src = 3'b000; st = 1; tr = 1;
    cyc("ext_trap", 32'h2000, 0, 32'h1234, 2, 1, 19);
    cyc("ext_held", 32'h2000, 1, 32'h1234, 2, 0, 19);
    st = 0; tr = 0;
    cyc("ext_post", 32'h2004, 1, 32'h1234, 2, 0, 20);
    src = 3'b111;
    cyc("mret", 32'h1234, 1, 32'h1234, 2, 0, 21);

    src = 3'b011; tar = 32'hFFFF_FFFC;
    cyc("to_top", 32'hFFFF_FFFC, 1, 32'h1234, 2, 0, 22);
    src = 3'b000;
    cyc("wrap", 32'h0, 1, 32'h1234, 2, 0, 23);
    tr = 1;
    cyc("trap3", 32'h2000, 0, 32'h0, 2, 1, 23);
    tr = 0; ra = 1;
    cyc("rst_in_trap", 32'h1000, 0, 0, 0, 0, 0);
    ra = 0;
    cyc("reboot", 32'h1000, 1, 0, 0, 0, 0);
    cyc("reseq", 32'h1004, 1, 0, 0, 0, 1);
    ra = 1;
    cyc("rst2", 32'h1000, 0, 0, 0, 0, 0);
    ra = 0; tr = 1;
    cyc("boot_trap", 32'h2000, 0, 32'h1000, 2, 1, 0);
    tr = 0;
    cyc("boot_trap_h", 32'h2000, 1, 32'h1000, 2, 0, 0);

    for (int i = 0; i < 10 && q.size() != 0; i++)
      @(negedge clk);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
